stall_flush_unit: RTL
=====================

Name: stall_flush_unit

Overview:
- Pipeline control block that generates stall and flush signals for the 5-stage RISC-V pipeline. It is the counterpart to the forwarding logic and covers the hazards that forwarding cannot resolve.
- Handles three cases: load-use hazards (D vs E), taken branches/jumps resolved in E, and multi-cycle data-memory waits in M via a ready handshake.
- Adds a memory-wait FSM with a timeout error flag and saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- MEM_TIMEOUT, 16, number of consecutive memory-stall cycles that raises MemTimeoutErr (legal range 2..255).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; asynchronous, active-low.
- Rs1D  in  5  source register 1 of the instruction in Decode.
- Rs2D  in  5  source register 2 of the instruction in Decode.
- RdE  in  5  destination register of the instruction in Execute.
- MemReadE  in  1  the instruction in Execute is a load.
- PCSrcE  in  1  branch taken or jump in Execute.
- MemReqM  in  1  the instruction in Memory is issuing a data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold the IF/ID register.
- StallE  out  1  hold the ID/EX register.
- StallM  out  1  hold the EX/MEM register.
- FlushD  out  1  clear the IF/ID register.
- FlushE  out  1  clear the ID/EX register.
- FlushW  out  1  clear the MEM/WB register (bubble into W).
- MemWaitState  out  1  1 while the FSM is in WAIT.
- MemTimeoutErr  out  1  sticky timeout error flag.
- LoadUseCnt  out  CNT_W  count of load-use stall cycles.
- MemStallCnt  out  CNT_W  count of memory-stall cycles.
- FlushCnt  out  CNT_W  count of branch-flush cycles.

Behaviour:
- Internal terms, all combinational:
  - memStall = MemReqM & ~MemReadyM.
  - lwStall = MemReadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- Priority is memStall > PCSrcE > lwStall. Outputs are combinational from these terms, with no added latency.
- When memStall: StallF, StallD, StallE and StallM are 1; FlushW is 1; FlushD and FlushE are 0.
  - Execute is frozen, so PCSrcE stays held. The branch flush therefore takes effect in the first cycle after the memory releases, with no pending register needed.
- Else when PCSrcE: FlushD and FlushE are 1; all stalls are 0.
  - A simultaneous lwStall is discarded, because the Decode instruction is being flushed anyway.
- Else when lwStall: StallF and StallD are 1, FlushE is 1, and all other outputs are 0. This is exactly a one-cycle bubble.
- Otherwise all stall and flush outputs are 0.
- FSM states are RUN and WAIT.
  - RUN goes to WAIT on a cycle where memStall is 1.
  - WAIT goes to RUN on a cycle where memStall is 0 (MemReadyM=1 or MemReqM dropped).
  - MemWaitState = (state == WAIT).
- WaitCnt is internal, 8 bits, saturating:
  - Set to 1 on the first memStall cycle.
  - Incremented on each consecutive memStall cycle.
  - Cleared to 0 on a cycle with memStall = 0.
- Timeout: on an edge where memStall = 1 and WaitCnt == MEM_TIMEOUT-1, MemTimeoutErr is set to 1.
  - MemTimeoutErr stays 1 until rst_n is asserted.
  - Stalls continue regardless of the error; the unit never auto-releases.
- Counters increment by 1 per clock edge, each saturating at all-ones:
  - MemStallCnt when memStall.
  - FlushCnt when PCSrcE & ~memStall.
  - LoadUseCnt when lwStall & ~memStall & ~PCSrcE.
- Reset (rst_n low, asynchronous, including mid-wait):
  - State goes to RUN; WaitCnt, all counters and MemTimeoutErr go to 0.
  - All stall and flush outputs are forced to 0 while rst_n is low.
- Register x0 never produces a load-use stall.

Decomposition:
- Package hazard_pkg holds:
  - the FSM state enum (RUN=0, WAIT=1);
  - the default CNT_W and MEM_TIMEOUT values;
  - the 5-bit register-index width constant.
- One natural sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated three times.

Test Plan:
- Load-use: MemReadE=1, RdE=5, Rs1D=5, no other hazards for one cycle -> StallF=StallD=FlushE=1 for exactly that cycle; LoadUseCnt goes 0->1.
- x0 and no-match: MemReadE=1, RdE=0, Rs1D=0 -> all outputs 0. Then RdE=7, Rs1D=3, Rs2D=4 -> all outputs 0.
- Branch beats load-use: PCSrcE=1 together with the load-use condition -> FlushD=FlushE=1, StallF=StallD=0; FlushCnt=1, LoadUseCnt=0.
- Memory wait with a held branch:
  - Stimulus: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1; PCSrcE=1 throughout.
  - Required during the wait: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0, MemWaitState=1 from cycle 2.
  - Required on the release cycle: FlushD=FlushE=1; MemStallCnt=3.
- Timeout: MEM_TIMEOUT=4, memStall held for 6 cycles -> MemTimeoutErr rises after the 4th stall-cycle edge and stays 1 after release; stalls stay asserted throughout.
- Reset mid-wait: rst_n pulsed low during WAIT with WaitCnt=2 -> outputs drop to 0 immediately, MemWaitState=0, all counters 0. A later memStall restarts WaitCnt from 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard (stall/flush) logic.
package hazard_pkg;

  // Memory-wait FSM states
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } memState_t;

  localparam int DefaultCntW       = 32;
  localparam int DefaultMemTimeout = 16;
  localparam int RegIdxW           = 5;

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per enabled edge, holding once every bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stall_flush_unit.sv
// Stall/flush generation for the 5-stage pipeline: load-use bubbles, branch
// flushes and data-memory waits, plus a wait watchdog and perf counters.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | no memory wait in progress on the previous edge
//   WAIT  | data memory held M stalled on the previous edge
module stall_flush_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = DefaultCntW,
  parameter int MEM_TIMEOUT = DefaultMemTimeout
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemWaitState,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] MemStallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  logic      memStall;
  logic      lwStall;
  memState_t state, stateNext;
  logic [7:0] waitCnt;

  assign memStall = MemReqM & ~MemReadyM;
  assign lwStall  = MemReadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // Hazard priority: memory wait, then taken branch, then load-use bubble.
  // Outputs are gated off while reset is held.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst_n) begin
      if (memStall) begin
        // E is frozen too, so a taken branch stays visible until release
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state: track whether memory is currently holding the pipe
  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (memStall)  stateNext = WAIT;
      WAIT:    if (!memStall) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  assign MemWaitState = (state == WAIT);

  // Consecutive-stall counter; saturating so a stuck memory cannot wrap it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (!memStall) begin
      waitCnt <= '0;
    end else if (waitCnt != 8'hFF) begin
      waitCnt <= waitCnt + 8'd1;
    end
  end

  // Sticky watchdog flag; only reset clears it and stalls are never released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MemTimeoutErr <= 1'b0;
    end else if (memStall && (waitCnt == TimeoutLast)) begin
      MemTimeoutErr <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) uMemStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (memStall),
    .count (MemStallCnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (PCSrcE & ~memStall),
    .count (FlushCnt)
  );

  sat_counter #(.W(CNT_W)) uLoadUseCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lwStall & ~memStall & ~PCSrcE),
    .count (LoadUseCnt)
  );

endmodule
